// File: rtl/gpio_in_cond_pkg.sv
// Shared GPIO defaults so the core and the input conditioner agree on width and filtering.
package gpio_in_cond_pkg;

    localparam int unsigned GPIO_WIDTH           = 32;
    localparam int unsigned GPIO_DEBOUNCE_CYCLES = 16;

    // Counter must hold values 0..cycles-1; one extra code keeps cycles=1 at a 1-bit counter.
    function automatic int unsigned gpio_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: two-flop synchronizer, debounce counter, stable level and sticky edge flags.
module gpio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    input  logic i_edge_clr,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rise;
    logic             r_fall;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Debounce next-state: count consecutive mismatches, accept on the last one.
    always_comb begin
        w_accept     = 1'b0;
        w_cnt_nxt    = '0;
        w_stable_nxt = r_stable;
        if (r_sync2 != r_stable) begin
            if (r_cnt == CntMax) begin
                w_accept     = 1'b1;
                w_stable_nxt = r_sync2;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
        // A new edge wins over a clear arriving on the same cycle.
        w_rise_nxt = (w_accept & r_sync2)  | (r_rise & ~i_edge_clr);
        w_fall_nxt = (w_accept & ~r_sync2) | (r_fall & ~i_edge_clr);
    end

    // State register with synchronous reset; reset never produces an edge flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1  <= RESET_VAL;
            r_sync2  <= RESET_VAL;
            r_stable <= RESET_VAL;
            r_cnt    <= '0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync1  <= i_pin;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-bit synchronize + debounce, sticky edge flags, edge summary.
module gpio_in_cond
    import gpio_in_cond_pkg::*;
#(
    parameter int unsigned      WIDTH           = GPIO_WIDTH,
    parameter int unsigned      DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] edge_rise,
    output logic [WIDTH-1:0] edge_fall,
    input  logic [WIDTH-1:0] edge_clr,
    output logic             edge_any
);

    localparam int unsigned CNT_W = gpio_cnt_w(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RESET_VAL      (RESET_VAL[g])
        ) u_bit (
            .i_clk     (sys_clk),
            .i_rst     (sys_rst),
            .i_pin     (pin_in[g]),
            .i_edge_clr(edge_clr[g]),
            .o_stable  (w_stable[g]),
            .o_rise    (w_rise[g]),
            .o_fall    (w_fall[g])
        );
    end

    assign gpio_in   = w_stable;
    assign edge_rise = w_rise;
    assign edge_fall = w_fall;
    assign edge_any  = |{w_rise, w_fall};

endmodule
